// File: rtl/matrix_result_capture_if.sv
// Host-side bundle for matrix_result_capture: arm/start handshake, the solver
// write stream, the element read port and the status flags.
interface matrix_result_capture_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              arm;
    logic              solver_start;
    logic [DATA_W-1:0] wr_data;
    logic [31:0]       wr_st;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              timeout;

    // Host / solver side: drives requests and the write stream, observes status.
    modport master (
        output arm, wr_data, wr_st, rd_en, rd_addr,
        input  solver_start, rd_data, rd_valid, busy, done, overflow, timeout
    );

    // Capture block side.
    modport slave (
        input  arm, wr_data, wr_st, rd_en, rd_addr,
        output solver_start, rd_data, rd_valid, busy, done, overflow, timeout
    );
endinterface

// File: rtl/matrix_result_capture.sv
// Captures one N*N result matrix streamed from the inverse_matrix solver into a
// local buffer, then serves element reads through a registered read port.
// Flags overflow (writes after completion) and timeout (solver stalled).
module matrix_result_capture #(
    parameter int N       = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    localparam int DEPTH   = N * N,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int TIMER_W = $clog2(TIMEOUT) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_result_capture_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [TIMER_W-1:0] EXPIRE_AT = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_en;
    logic               word_valid;

    // Result buffer; plain array so it maps onto on-chip RAM.
    logic [DATA_W-1:0]  buf_mem [0:DEPTH-1];

    // Only bit 0 of the solver status qualifies a word; the rest is ignored.
    assign word_valid = bus.wr_st[0];
    logic unused_wr_st;
    assign unused_wr_st = ^bus.wr_st[31:1];

    // Next-state and control: sequencing, write pointer, stall timer, sticky flags.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.arm) state_d = START;
            end
            START: begin
                wr_ptr_d   = '0;
                timer_d    = '0;
                overflow_d = 1'b0;
                timeout_d  = 1'b0;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
                if (word_valid) wr_en = 1'b1;
                // A completing write beats a same-cycle timer expiry.
                if (word_valid && wr_ptr_q == LAST_PTR) begin
                    state_d = DONE;
                end else begin
                    if (word_valid) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (timer_q >= EXPIRE_AT) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            DONE: begin
                if (word_valid) overflow_d = 1'b1;
                if (bus.arm) state_d = START;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port: old buffer contents are sampled, so a same-cycle write is not seen.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) begin
            rd_data_d = (bus.rd_addr < DEPTH_A) ? buf_mem[bus.rd_addr] : '0;
        end
    end

    // Control and read-port registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Buffer write; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.solver_start = (state_q == START);
    assign bus.busy         = (state_q == START) || (state_q == CAPTURE);
    assign bus.done         = (state_q == DONE);
    assign bus.overflow     = overflow_q;
    assign bus.timeout      = timeout_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_matrix_result_capture.sv
// Directed bench for matrix_result_capture (N=3, TIMEOUT=16).
module tb_matrix_result_capture;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_result_capture_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    matrix_result_capture #(.N(3), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int wcount   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm     = 1'b0;
        bus.wr_data = '0;
        bus.wr_st   = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
    endtask

    // Pulse arm; returns solver_start as seen in the START cycle; ends in CAPTURE.
    task automatic arm_dut(output logic saw_start);
        bus.arm = 1'b1;
        tick();
        saw_start = bus.solver_start;
        bus.arm = 1'b0;
        $display("arm: solver_start=%0b busy=%0b", bus.solver_start, bus.busy);
        tick();
        wcount = 0;
    endtask

    // Drive ncyc solver cycles; mask bit k marks a valid word (base+wcount).
    task automatic drive_capture(input int ncyc, input logic [31:0] mask,
                                 input logic [31:0] base, input int arm_at,
                                 output int nstarts);
        nstarts = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (mask[k]) begin
                bus.wr_st   = 32'h0000_0001;
                bus.wr_data = base + 32'(wcount);
                wcount++;
            end else begin
                bus.wr_st   = 32'hFFFF_FFFE;
                bus.wr_data = 32'hBAD0_0000 + 32'(k);
            end
            bus.arm = (k == arm_at);
            tick();
            if (bus.solver_start) nstarts++;
            $display("wr k=%0d st=%h data=%h busy=%0b done=%0b", k, bus.wr_st, bus.wr_data, bus.busy, bus.done);
        end
        bus.wr_st = '0;
        bus.arm   = 1'b0;
    endtask

    task automatic read_word(input logic [3:0] a, output logic [31:0] d, output logic v);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
        d = bus.rd_data;
        v = bus.rd_valid;
        $display("rd addr=%0d data=%h valid=%0b", a, d, v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.solver_start, bus.busy, bus.done, bus.overflow, bus.timeout, bus.rd_valid, bus.rd_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got ss/busy/done/ovf/to/rv=%b%b%b%b%b%b rd_data=%h expected all 0",
                     bus.solver_start, bus.busy, bus.done, bus.overflow, bus.timeout, bus.rd_valid, bus.rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic s; int n; logic [31:0] d; logic v;
        arm_dut(s);
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL start_pulse: got %0b expected 1", s); end
        checks++; if (bus.solver_start !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL start_one_cycle: got ss=%0b busy=%0b expected ss=0 busy=1", bus.solver_start, bus.busy); end
        drive_capture(8, 32'h0FF, 32'h1000, -1, n);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL done_early: got done=%0b busy=%0b expected 0/1", bus.done, bus.busy); end
        drive_capture(1, 32'h1, 32'h1000, -1, n);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_after_9: got done=%0b busy=%0b expected 1/0", bus.done, bus.busy); end
        for (int i = 0; i < 9; i++) begin
            read_word(4'(i), d, v);
            checks++;
            if (d !== 32'h1000 + 32'(i) || v !== 1'b1) begin
                failures++;
                $display("FAIL basic_read[%0d]: got %h valid=%0b expected %h valid=1", i, d, v, 32'h1000 + 32'(i));
            end
        end
        tick();
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h1008) begin failures++; $display("FAIL rd_hold: got valid=%0b data=%h expected 0/00001008", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_overflow();
        logic s; int n; logic [31:0] d; logic v;
        bus.wr_st   = 32'h1;
        bus.wr_data = 32'h0000_DEAD;
        tick();
        bus.wr_st = '0;
        checks++; if (bus.overflow !== 1'b1 || bus.done !== 1'b1) begin failures++; $display("FAIL overflow_set: got ovf=%0b done=%0b expected 1/1", bus.overflow, bus.done); end
        read_word(4'd8, d, v);
        checks++; if (d !== 32'h1008) begin failures++; $display("FAIL overflow_no_write: got %h expected 00001008", d); end
        read_word(4'd0, d, v);
        checks++; if (d !== 32'h1000) begin failures++; $display("FAIL overflow_addr0: got %h expected 00001000", d); end
        arm_dut(s);
        checks++; if (s !== 1'b1 || bus.overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear: got start=%0b ovf=%0b expected 1/0", s, bus.overflow); end
        drive_capture(9, 32'h1FF, 32'h3000, -1, n);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL back_to_back_done: got %0b expected 1", bus.done); end
        read_word(4'd5, d, v);
        checks++; if (d !== 32'h3005) begin failures++; $display("FAIL back_to_back_read: got %h expected 00003005", d); end
    endtask

    // Alternating valid/gap; 9th word lands on the last allowed (expiry) cycle.
    task automatic test_gapped();
        logic s; int n; logic [31:0] d; logic v;
        arm_dut(s);
        drive_capture(15, 32'h0000_5555, 32'h4000, -1, n);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL gapped_pending: got done=%0b busy=%0b expected 0/1", bus.done, bus.busy); end
        drive_capture(1, 32'h1, 32'h4000, -1, n);
        checks++; if (bus.done !== 1'b1 || bus.timeout !== 1'b0) begin failures++; $display("FAIL expiry_win: got done=%0b timeout=%0b expected 1/0", bus.done, bus.timeout); end
        read_word(4'd1, d, v);
        checks++; if (d !== 32'h4001) begin failures++; $display("FAIL gapped_read1: got %h expected 00004001", d); end
        read_word(4'd8, d, v);
        checks++; if (d !== 32'h4008) begin failures++; $display("FAIL gapped_read8: got %h expected 00004008", d); end
    endtask

    task automatic test_timeout();
        logic s; int n; logic [31:0] d; logic v;
        arm_dut(s);
        drive_capture(15, 32'h1F, 32'h5000, -1, n);
        checks++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL timeout_early: got to=%0b busy=%0b expected 0/1", bus.timeout, bus.busy); end
        drive_capture(1, 32'h0, 32'h5000, -1, n);
        checks++; if (bus.timeout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL timeout_set: got to=%0b busy=%0b done=%0b expected 1/0/0", bus.timeout, bus.busy, bus.done); end
        read_word(4'd4, d, v);
        checks++; if (d !== 32'h5004) begin failures++; $display("FAIL timeout_partial: got %h expected 00005004", d); end
        read_word(4'd5, d, v);
        checks++; if (d !== 32'h4005) begin failures++; $display("FAIL timeout_retained: got %h expected 00004005", d); end
    endtask

    task automatic test_rbw();
        logic s; int n; logic [31:0] d; logic v;
        arm_dut(s);
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %0b expected 0", bus.timeout); end
        bus.wr_st   = 32'h1;
        bus.wr_data = 32'h6000;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        tick();
        bus.wr_st = '0;
        bus.rd_en = 1'b0;
        $display("rbw addr=0 data=%h valid=%0b", bus.rd_data, bus.rd_valid);
        checks++; if (bus.rd_data !== 32'h5000 || bus.rd_valid !== 1'b1) begin failures++; $display("FAIL read_before_write: got %h valid=%0b expected 00005000 valid=1", bus.rd_data, bus.rd_valid); end
        wcount = 1;
        drive_capture(8, 32'hFF, 32'h6000, -1, n);
        read_word(4'd0, d, v);
        checks++; if (d !== 32'h6000 || bus.done !== 1'b1) begin failures++; $display("FAIL rbw_after: got %h done=%0b expected 00006000 done=1", d, bus.done); end
    endtask

    task automatic test_reset_mid();
        logic s; int n; logic [31:0] d; logic v;
        arm_dut(s);
        drive_capture(4, 32'hF, 32'h7000, -1, n);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({bus.solver_start, bus.busy, bus.done, bus.overflow, bus.timeout, bus.rd_valid, bus.rd_data} !== 38'd0) begin
            failures++;
            $display("FAIL async_reset: got ss/busy/done/ovf/to/rv=%b%b%b%b%b%b rd_data=%h expected all 0",
                     bus.solver_start, bus.busy, bus.done, bus.overflow, bus.timeout, bus.rd_valid, bus.rd_data);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got done=%0b busy=%0b expected 0/0", bus.done, bus.busy); end
        arm_dut(s);
        drive_capture(9, 32'h1FF, 32'h8000, -1, n);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL recapture_done: got %0b expected 1", bus.done); end
        read_word(4'd3, d, v);
        checks++; if (d !== 32'h8003) begin failures++; $display("FAIL recapture_read3: got %h expected 00008003", d); end
    endtask

    task automatic test_bad_addr_and_busy_arm();
        logic s; int n; logic [31:0] d; logic v;
        read_word(4'd9, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin failures++; $display("FAIL bad_addr9: got %h valid=%0b expected 0 valid=1", d, v); end
        read_word(4'd15, d, v);
        checks++; if (d !== 32'h0 || v !== 1'b1) begin failures++; $display("FAIL bad_addr15: got %h valid=%0b expected 0 valid=1", d, v); end
        arm_dut(s);
        drive_capture(9, 32'h1FF, 32'h9000, 2, n);
        checks++; if (n !== 0 || bus.done !== 1'b1) begin failures++; $display("FAIL arm_while_busy: got extra_starts=%0d done=%0b expected 0/1", n, bus.done); end
        tick();
        checks++; if (bus.solver_start !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL arm_not_queued: got ss=%0b done=%0b expected 0/1", bus.solver_start, bus.done); end
        read_word(4'd7, d, v);
        checks++; if (d !== 32'h9007) begin failures++; $display("FAIL busy_arm_read7: got %h expected 00009007", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_gapped();
        test_timeout();
        test_rbw();
        test_reset_mid();
        test_bad_addr_and_busy_arm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
